buzzer_env_driver: RTL and testbench
====================================

BUZZER_ENV_DRIVER -- requirements
Module: buzzer_env_driver

Interface
REQ-001 SHALL have parameter ENV_STEP, default 50000, meaning clk cycles per envelope step (1 ms at 50 MHz); legal range is 2 or greater.
REQ-002 SHALL have parameter STEP_SIZE, default 8, meaning the envelope level change per step.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port tone_in, input, 1 bit: square-wave note carrier from the tone generator stage; not synchronous to clk.
REQ-006 SHALL have port note_strobe, input, 1 bit: 1-cycle pulse at each beat boundary.
REQ-007 SHALL have port rest, input, 1 bit: sampled only with note_strobe; 1 means the new beat is silent.
REQ-008 SHALL have port vol, input, 3 bits: volume 0..7.
REQ-009 SHALL have port mute, input, 1 bit: level-sensitive mute request.
REQ-010 SHALL have port buzz_out, output, 1 bit: registered buzzer drive.
REQ-011 SHALL have port env_level, output, 8 bits: current envelope level.
REQ-012 SHALL have port active, output, 1 bit: 1 when state is not IDLE.

Function
REQ-013 SHALL resynchronise tone_in through 2 flops (tone_s); tone_in has no other path into the block.
REQ-014 SHALL compute target = vol*32 (values 0..224).
REQ-015 SHALL run an 8-bit pwm_cnt, free-running at clk and wrapping 255 to 0.
REQ-016 SHALL register buzz_out <= tone_s AND (pwm_cnt < env_level); buzz_out is 0 whenever env_level = 0.
REQ-017 SHALL run a step prescaler: step_tick pulses every ENV_STEP cycles; the prescaler clears to 0 on each entry to ATTACK or RELEASE.
REQ-018 SHALL change env_level only on cycles where step_tick = 1.
REQ-019 SHALL implement FSM states IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-020 IDLE SHALL transition to ATTACK on note_strobe & !rest & !mute.
REQ-021 ATTACK SHALL, on each step_tick:
- if level < target, set level = min(level+STEP_SIZE, target);
- if level > target, set level = max(level-STEP_SIZE, target);
- go to SUSTAIN in the cycle the level equals target.
REQ-022 SUSTAIN SHALL hold the level; if target differs from level, it SHALL return to ATTACK (re-track).
REQ-023 ATTACK and SUSTAIN SHALL go to RELEASE on note_strobe & rest, or on mute = 1.
REQ-024 A note_strobe with !rest in ATTACK or SUSTAIN SHALL re-enter ATTACK starting from the current level, with no reset to 0 (legato).
REQ-025 RELEASE SHALL, on each step_tick, set level = max(level-STEP_SIZE, 0), and go to IDLE in the cycle the level reaches 0.
REQ-026 RELEASE SHALL go to ATTACK on note_strobe & !rest & !mute.
REQ-027 Simultaneous events SHALL resolve by priority: mute, then note_strobe, then step_tick.
- When mute = 1, note_strobe SHALL be ignored.
REQ-028 vol = 0 in ATTACK SHALL ramp the level down to 0, then go to SUSTAIN with active = 1 and silent output.
REQ-029 All arithmetic SHALL saturate; env_level SHALL never wrap below 0 or above 224.
REQ-030 active SHALL be combinational from the state register (state != IDLE).

Reset
REQ-031 Assertion of rst_n SHALL asynchronously force state = IDLE, env_level = 0, buzz_out = 0, pwm_cnt = 0, prescaler = 0, and synchroniser flops = 0.
REQ-032 Reset mid-note SHALL silence buzz_out immediately, with no release ramp.
REQ-033 After deassertion, the block SHALL wait in IDLE for the next note_strobe.

Verification (sim with ENV_STEP=4, STEP_SIZE=8)
REQ-034 Attack: vol=4, strobe with rest=0 -> env_level reaches 128 after 16 step_ticks (64 cycles), then state is SUSTAIN.
REQ-035 Release: from SUSTAIN at 128, strobe with rest=1 -> level falls by 8 per 4 cycles, reaches 0 after 64 cycles, then IDLE with active=0.
REQ-036 Mute priority: mute=1 in the same cycle as strobe with rest=0 from IDLE -> stays IDLE; mute during SUSTAIN at 224 -> RELEASE.
REQ-037 Re-track: in SUSTAIN at 128, vol changes 4->2 -> ATTACK, level falls to 64 in 8 steps, then SUSTAIN.
REQ-038 PWM duty: level 64, tone_in held at 1 -> buzz_out is high in exactly 64 of every 256 cycles; tone_in held at 0 -> buzz_out stays 0.
REQ-039 Reset mid-attack at level 40 -> buzz_out=0, env_level=0, active=0 asynchronously; after release, no output until the next strobe.

Source files
------------

// File: rtl/buzzer_env_driver.sv
// buzzer_env_driver
//   Applies a volume envelope (attack / sustain / release) to the square-wave
//   note carrier and drives the buzzer with a PWM-gated version of it.
//
//   Parameters
//     ENV_STEP   clk cycles per envelope step (>= 2)
//     STEP_SIZE  envelope level change per step
//
//   Ports
//     clk          clock
//     rst_n        asynchronous active-low reset
//     tone_in      note carrier, asynchronous to clk (resynchronised here)
//     note_strobe  1-cycle pulse at each beat boundary
//     rest         qualifies note_strobe: 1 = new beat is silent
//     vol          volume 0..7, envelope target = vol*32
//     mute         level-sensitive mute request
//     buzz_out     registered buzzer drive
//     env_level    current envelope level (0..224)
//     active       envelope state machine is not idle
module buzzer_env_driver #(
  parameter int ENV_STEP  = 50000,
  parameter int STEP_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  input  logic       note_strobe,
  input  logic       rest,
  input  logic [2:0] vol,
  input  logic       mute,
  output logic       buzz_out,
  output logic [7:0] env_level,
  output logic       active
);

  localparam int              PW         = $clog2(ENV_STEP);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(ENV_STEP - 1);
  // Level arithmetic is done 16 bits wide so sums/differences never wrap
  // before the saturation compare.
  localparam logic [15:0]     STEP       = 16'(STEP_SIZE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [7:0]    level_nxt;
  logic          tone_meta, tone_s;
  logic [7:0]    pwm_cnt;
  logic [PW-1:0] presc;
  logic          presc_clr;
  logic          step_tick;
  logic [7:0]    target;
  logic [15:0]   lvl_w, tgt_w;
  logic [7:0]    lvl_up, lvl_dn, lvl_rel, lvl_track;

  assign active = (state != S_IDLE);
  assign target = {vol, 5'd0};

  // Two-flop resynchroniser; tone_s is the only use of the carrier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_meta <= 1'b0;
      tone_s    <= 1'b0;
    end else begin
      tone_meta <= tone_in;
      tone_s    <= tone_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= 8'd0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buzz_out <= 1'b0;
    else        buzz_out <= tone_s & (pwm_cnt < env_level);
  end

  // Prescaler restarts on every entry to ATTACK/RELEASE so the first step
  // lands a full ENV_STEP cycles after the event that started the ramp.
  assign step_tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      presc <= '0;
    else if (presc_clr || step_tick) presc <= '0;
    else                             presc <= presc + 1'b1;
  end

  // Saturating step candidates.
  assign lvl_w   = {8'd0, env_level};
  assign tgt_w   = {8'd0, target};
  assign lvl_up  = (lvl_w + STEP >= tgt_w) ? target : 8'(lvl_w + STEP);
  assign lvl_dn  = (lvl_w >= tgt_w + STEP) ? 8'(lvl_w - STEP) : target;
  assign lvl_rel = (lvl_w >= STEP) ? 8'(lvl_w - STEP) : 8'd0;
  assign lvl_track = (env_level < target) ? lvl_up :
                     (env_level > target) ? lvl_dn : env_level;

  // Event priority inside each state: mute, then note_strobe, then step_tick.
  always_comb begin
    state_nxt = state;
    level_nxt = env_level;
    presc_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (note_strobe && !rest && !mute) begin
          state_nxt = S_ATTACK;
          presc_clr = 1'b1;
        end
      end
      S_ATTACK, S_SUSTAIN: begin
        if (mute || (note_strobe && rest)) begin
          state_nxt = S_RELEASE;
          presc_clr = 1'b1;
        end else if (note_strobe) begin
          // Legato: restart the ramp from wherever the level is now.
          state_nxt = S_ATTACK;
          presc_clr = 1'b1;
        end else if (state == S_SUSTAIN) begin
          if (env_level != target) begin
            state_nxt = S_ATTACK;
            presc_clr = 1'b1;
          end
        end else begin
          if (step_tick) level_nxt = lvl_track;
          if (level_nxt == target) state_nxt = S_SUSTAIN;
        end
      end
      S_RELEASE: begin
        if (!mute && note_strobe && !rest) begin
          state_nxt = S_ATTACK;
          presc_clr = 1'b1;
        end else begin
          if (step_tick) level_nxt = lvl_rel;
          if (level_nxt == 8'd0) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      env_level <= 8'd0;
    end else begin
      state     <= state_nxt;
      env_level <= level_nxt;
    end
  end

endmodule

// File: tb/tb_buzzer_env_driver.sv
module tb_buzzer_env_driver;
  localparam int ENV_STEP  = 4;
  localparam int STEP_SIZE = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tone_in = 1'b0;
  logic       note_strobe = 1'b0;
  logic       rest = 1'b0;
  logic       mute = 1'b0;
  logic [2:0] vol = 3'd0;
  logic       buzz_out;
  logic [7:0] env_level;
  logic       active;

  int n_assert = 0;
  int n_fail   = 0;

  buzzer_env_driver #(.ENV_STEP(ENV_STEP), .STEP_SIZE(STEP_SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .note_strobe (note_strobe),
    .rest        (rest),
    .vol         (vol),
    .mute        (mute),
    .buzz_out    (buzz_out),
    .env_level   (env_level),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; return just after the edge so outputs are settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic r);
    note_strobe = 1'b1;
    rest        = r;
    cyc();
    note_strobe = 1'b0;
    rest        = 1'b0;
  endtask

  // Reference envelope: a ramp that started at edge 0 moves one STEP_SIZE
  // every ENV_STEP edges toward its goal and clamps there.
  function automatic int ramp(input int start, input int goal, input int j);
    int l;
    if (start <= goal) begin
      l = start + STEP_SIZE * (j / ENV_STEP);
      return (l > goal) ? goal : l;
    end
    l = start - STEP_SIZE * (j / ENV_STEP);
    return (l < goal) ? goal : l;
  endfunction

  // Caller has just passed edge 0 of an ATTACK ramp; checks edges 0..n.
  task automatic ramp_chk(input string tag, input int start, input int goal, input int n);
    for (int j = 0; j <= n; j++) begin
      if (j > 0) cyc();
      chk($sformatf("%s_level[%0d]", tag, j), {24'd0, env_level}, 32'(ramp(start, goal, j)));
      chk($sformatf("%s_active[%0d]", tag, j), {31'd0, active}, 32'd1);
    end
  endtask

  // Caller has just passed edge 0 of a RELEASE; the block goes idle on the
  // edge where the level reaches zero.
  task automatic rel_chk(input string tag, input int start, input int n);
    int e;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) cyc();
      e = ramp(start, 0, j);
      chk($sformatf("%s_level[%0d]", tag, j), {24'd0, env_level}, 32'(e));
      chk($sformatf("%s_active[%0d]", tag, j), {31'd0, active}, ((j == 0) || (e > 0)) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic duty(output int c);
    c = 0;
    repeat (256) begin
      cyc();
      if (buzz_out === 1'b1) c++;
    end
  endtask

  initial begin
    int cnt, v, t, um, act_cnt;

    // Reset state
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_level",  {24'd0, env_level}, 32'd0);
    chk("rst_active", {31'd0, active},    32'd0);
    chk("rst_buzz",   {31'd0, buzz_out},  32'd0);
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("idle_wait_active", {31'd0, active}, 32'd0);

    // Mute wins over a note strobe from IDLE; a rest strobe does nothing
    vol  = 3'd4;
    mute = 1'b1;
    strobe(1'b0);
    mute = 1'b0;
    cyc();
    chk("mute_strobe_active", {31'd0, active},    32'd0);
    chk("mute_strobe_level",  {24'd0, env_level}, 32'd0);
    strobe(1'b1);
    cyc();
    chk("rest_strobe_active", {31'd0, active}, 32'd0);

    // Attack to 128, re-track down to 64, PWM duty, back to 128, release
    strobe(1'b0);
    ramp_chk("attack128", 0, 128, 67);
    vol = 3'd2;
    cyc();
    ramp_chk("retrack64", 128, 64, 35);
    tone_in = 1'b1;
    repeat (4) cyc();
    duty(cnt);
    chk("duty64", 32'(cnt), 32'd64);
    tone_in = 1'b0;
    repeat (4) cyc();
    duty(cnt);
    chk("duty_tone0", 32'(cnt), 32'd0);
    vol = 3'd4;
    cyc();
    ramp_chk("retrack128", 64, 128, 35);
    strobe(1'b1);
    rel_chk("release128", 128, 67);

    // vol = 0 from IDLE: active but silent, then mute releases at once
    vol = 3'd0;
    strobe(1'b0);
    ramp_chk("vol0", 0, 0, 8);
    tone_in = 1'b1;
    repeat (4) cyc();
    duty(cnt);
    chk("duty_vol0", 32'(cnt), 32'd0);
    tone_in = 1'b0;
    mute = 1'b1;
    cyc();
    rel_chk("mute_vol0", 0, 4);
    mute = 1'b0;
    cyc();

    // Randomised notes; the first one is full volume released by mute
    for (int it = 0; it < 6; it++) begin
      v  = (it == 0) ? 7 : int'($urandom_range(7, 1));
      t  = (it == 0) ? 1 : int'($urandom_range(1, 0));
      um = (it == 0) ? 1 : int'($urandom_range(1, 0));
      vol = 3'(v);
      strobe(1'b0);
      ramp_chk($sformatf("rnd%0d_attack", it), 0, 32 * v, 16 * v + 3);
      tone_in = t[0];
      repeat (4) cyc();
      duty(cnt);
      chk($sformatf("rnd%0d_duty", it), 32'(cnt), (t != 0) ? 32'(32 * v) : 32'd0);
      tone_in = 1'b0;
      if (um != 0) begin
        mute = 1'b1;
        cyc();
      end else begin
        strobe(1'b1);
      end
      rel_chk($sformatf("rnd%0d_release", it), 32 * v, 16 * v + 3);
      mute = 1'b0;
      cyc();
    end

    // Legato: a new note mid-attack continues from the current level and
    // restarts the step timing
    vol = 3'd4;
    strobe(1'b0);
    ramp_chk("legato_pre", 0, 128, 10);
    strobe(1'b0);
    ramp_chk("legato", 16, 128, 60);
    vol = 3'd0;
    cyc();
    ramp_chk("vol0_down", 128, 0, 67);
    tone_in = 1'b1;
    repeat (4) cyc();
    duty(cnt);
    chk("duty_vol0_down", 32'(cnt), 32'd0);
    tone_in = 1'b0;
    strobe(1'b1);
    rel_chk("rel_from0", 0, 4);

    // Reset mid-attack at level 40 silences everything asynchronously
    tone_in = 1'b1;
    vol = 3'd4;
    strobe(1'b0);
    ramp_chk("pre_reset", 0, 128, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level",  {24'd0, env_level}, 32'd0);
    chk("async_rst_active", {31'd0, active},    32'd0);
    chk("async_rst_buzz",   {31'd0, buzz_out},  32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cnt = 0;
    act_cnt = 0;
    repeat (40) begin
      cyc();
      if (buzz_out !== 1'b0) cnt++;
      if (active !== 1'b0) act_cnt++;
    end
    chk("post_rst_buzz_cycles",   32'(cnt),     32'd0);
    chk("post_rst_active_cycles", 32'(act_cnt), 32'd0);
    strobe(1'b0);
    chk("post_rst_restart_active", {31'd0, active}, 32'd1);
    tone_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
